// File: rtl/reservation_alu3_issue_if.sv
// ---------------------------------------------------------------------------
// reservation_alu3_issue_if
// Purpose : Groups the signals between the ALU3 reservation entries, the
//           issue-select stage and the ALU3 execution unit into one bundle.
// Signals :
//   iFLUSH              pipeline flush
//   iINFO_ENTRY_VALID   per-entry occupied flag
//   iINFO_MATCHING      per-entry ready / in-order match
//   iINFO_PAYLOAD       packed per-entry payload, entry k at [k*PAYLOAD_W +: PAYLOAD_W]
//   oENTRY_EXOUT_VALID  one-hot grant back to the entries
//   oEXOUT_VALID        issue slot holds a valid instruction
//   oEXOUT_PAYLOAD      registered payload of the issued entry
//   iEXOUT_LOCK         execution unit busy
//   oINFO_RR_POINTER    round-robin start index
// Modports: slave = issue stage, master = environment (entries + exec unit).
// ---------------------------------------------------------------------------
interface reservation_alu3_issue_if #(
  parameter int ENTRY     = 4,
  parameter int PTR_W     = 2,
  parameter int PAYLOAD_W = 130
);
  logic                         iFLUSH;
  logic [ENTRY-1:0]             iINFO_ENTRY_VALID;
  logic [ENTRY-1:0]             iINFO_MATCHING;
  logic [ENTRY*PAYLOAD_W-1:0]   iINFO_PAYLOAD;
  logic [ENTRY-1:0]             oENTRY_EXOUT_VALID;
  logic                         oEXOUT_VALID;
  logic [PAYLOAD_W-1:0]         oEXOUT_PAYLOAD;
  logic                         iEXOUT_LOCK;
  logic [PTR_W-1:0]             oINFO_RR_POINTER;

  modport slave (
    input  iFLUSH, iINFO_ENTRY_VALID, iINFO_MATCHING, iINFO_PAYLOAD, iEXOUT_LOCK,
    output oENTRY_EXOUT_VALID, oEXOUT_VALID, oEXOUT_PAYLOAD, oINFO_RR_POINTER
  );

  modport master (
    output iFLUSH, iINFO_ENTRY_VALID, iINFO_MATCHING, iINFO_PAYLOAD, iEXOUT_LOCK,
    input  oENTRY_EXOUT_VALID, oEXOUT_VALID, oEXOUT_PAYLOAD, oINFO_RR_POINTER
  );
endinterface

// File: rtl/reservation_alu3_issue.sv
// ---------------------------------------------------------------------------
// reservation_alu3_issue
// Purpose : Issue-select stage behind the ALU3 reservation entries. Each
//           cycle it picks one ready entry in round-robin order, pulses that
//           entry's execute-out strobe so it frees itself, and registers the
//           entry payload into the issue slot feeding the ALU3 unit. Holds
//           under execution-unit lock, drops the slot on flush.
// Ports   :
//   iCLOCK       clock
//   iRESET_SYNC  synchronous active-high reset
//   bus          reservation_alu3_issue_if.slave (entries, grant, issue slot,
//                lock, flush, round-robin pointer)
// ---------------------------------------------------------------------------
module reservation_alu3_issue #(
  parameter int ENTRY     = 4,
  parameter int PTR_W     = 2,
  parameter int PAYLOAD_W = 130
) (
  input  logic                           iCLOCK,
  input  logic                           iRESET_SYNC,
  reservation_alu3_issue_if.slave        bus
);

  logic [ENTRY-1:0]     w_req;
  logic [PTR_W-1:0]     w_idx;
  logic [PTR_W-1:0]     w_sel;
  logic                 w_found;
  logic [PAYLOAD_W-1:0] w_sel_payload;
  logic                 w_slot_free;
  logic                 w_xfer;
  logic                 w_load;
  logic [ENTRY-1:0]     w_grant;

  logic                 r_exout_vld_p1;
  logic [PAYLOAD_W-1:0] r_exout_payload_p1;
  logic [PTR_W-1:0]     r_rr_ptr;

  // An entry requests only when it is occupied and its operands are ready.
  assign w_req = bus.iINFO_ENTRY_VALID & bus.iINFO_MATCHING;

  // Round-robin scan starting at the pointer; ENTRY is a power of two, so
  // the PTR_W-bit addition wraps modulo ENTRY on its own.
  always_comb begin
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < ENTRY; i++) begin
      w_idx = r_rr_ptr + PTR_W'(i);
      if (!w_found && w_req[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_payload = '0;
    for (int i = 0; i < ENTRY; i++) begin
      if (w_sel == PTR_W'(i)) begin
        w_sel_payload = bus.iINFO_PAYLOAD[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  // A slot that hands off this cycle can accept a new load in the same
  // cycle, which gives one issue per cycle without bubbles.
  assign w_xfer      = r_exout_vld_p1 & ~bus.iEXOUT_LOCK;
  assign w_slot_free = ~r_exout_vld_p1 | ~bus.iEXOUT_LOCK;
  assign w_load      = w_found & w_slot_free & ~bus.iFLUSH & ~iRESET_SYNC;
  assign w_grant     = w_load ? (ENTRY'(1) << w_sel) : '0;

  // ---- stage p0 -> p1: issue slot register --------------------------------
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_exout_vld_p1     <= 1'b0;
      r_exout_payload_p1 <= '0;
      r_rr_ptr           <= '0;
    end else if (bus.iFLUSH) begin
      // A hand-off in the flush cycle is discarded with the slot.
      r_exout_vld_p1     <= 1'b0;
      r_exout_payload_p1 <= '0;
    end else if (w_load) begin
      r_exout_vld_p1     <= 1'b1;
      r_exout_payload_p1 <= w_sel_payload;
      r_rr_ptr           <= w_sel + PTR_W'(1);
    end else if (w_xfer) begin
      r_exout_vld_p1     <= 1'b0;
    end
  end

  assign bus.oENTRY_EXOUT_VALID = w_grant;
  assign bus.oEXOUT_VALID       = r_exout_vld_p1;
  assign bus.oEXOUT_PAYLOAD     = r_exout_payload_p1;
  assign bus.oINFO_RR_POINTER   = r_rr_ptr;

endmodule

// File: tb/tb_reservation_alu3_issue.sv
module tb_reservation_alu3_issue;
  localparam int ENTRY = 4;
  localparam int PTR_W = 2;
  localparam int PW    = 130;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ENTRY-1:0]    ev;
  logic [ENTRY-1:0]    mt;
  logic                fl;
  logic                lk;
  logic [PW-1:0]       pay [ENTRY];
  logic [ENTRY*PW-1:0] pk;

  int n_pass  = 0;
  int n_total = 0;

  reservation_alu3_issue_if #(.ENTRY(ENTRY), .PTR_W(PTR_W), .PAYLOAD_W(PW)) bus ();

  reservation_alu3_issue #(.ENTRY(ENTRY), .PTR_W(PTR_W), .PAYLOAD_W(PW)) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .bus         (bus)
  );

  always_comb begin
    pk = '0;
    for (int k = 0; k < ENTRY; k++) pk[k*PW +: PW] = pay[k];
  end

  assign bus.iFLUSH            = fl;
  assign bus.iINFO_ENTRY_VALID = ev;
  assign bus.iINFO_MATCHING    = mt;
  assign bus.iINFO_PAYLOAD     = pk;
  assign bus.iEXOUT_LOCK       = lk;

  // Behavioural reference: issue slot contents, slot valid, round-robin start.
  bit            started = 0;
  bit            m_vld   = 0;
  logic [PW-1:0] m_pay   = '0;
  int            m_ptr   = 0;
  logic [ENTRY-1:0] m_gnt = '0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Index of the entry that must be granted now, or -1 for no grant.
  function automatic int exp_idx();
    if (rst || fl) return -1;
    if (m_vld && lk) return -1;
    for (int i = 0; i < ENTRY; i++) begin
      int k = (m_ptr + i) % ENTRY;
      if (ev[k] && mt[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [ENTRY-1:0] exp_gnt();
    int e = exp_idx();
    logic [ENTRY-1:0] g = '0;
    if (e >= 0) g[e] = 1'b1;
    return g;
  endfunction

  always @(posedge clk) begin
    int e;
    e     = exp_idx();
    m_gnt = exp_gnt();
    if (rst) begin
      m_vld = 0; m_pay = '0; m_ptr = 0; started = 1;
    end else if (fl) begin
      m_vld = 0; m_pay = '0;
    end else if (e >= 0) begin
      m_vld = 1; m_pay = pay[e]; m_ptr = (e + 1) % ENTRY;
    end else if (m_vld && !lk) begin
      m_vld = 0;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("grant",   PW'(bus.oENTRY_EXOUT_VALID), PW'(exp_gnt()));
      chk("valid",   PW'(bus.oEXOUT_VALID),       PW'(m_vld));
      chk("payload", bus.oEXOUT_PAYLOAD,          m_pay);
      chk("pointer", PW'(bus.oINFO_RR_POINTER),   PW'(m_ptr));
    end
  end

  function automatic logic [PW-1:0] mkpay(input logic [5:0] tag, input logic [31:0] pc);
    logic [95:0] r = {$urandom, $urandom, $urandom};
    return {r[91:0], tag, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_slot(input string nm, input logic v, input logic [5:0] tag, input logic [31:0] pc);
    chk({nm, "_valid"}, PW'(bus.oEXOUT_VALID), PW'(v));
    chk({nm, "_tag"},   PW'(bus.oEXOUT_PAYLOAD[37:32]), PW'(tag));
    chk({nm, "_pc"},    PW'(bus.oEXOUT_PAYLOAD[31:0]), PW'(pc));
  endtask

  initial begin
    logic [ENTRY-1:0] one;
    rst = 1'b1; fl = 1'b0; lk = 1'b0; ev = 4'hF; mt = 4'hF;
    for (int k = 0; k < ENTRY; k++) pay[k] = mkpay(6'(10 + k), 32'h100 * k);

    // Reset with all entries requesting.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", PW'(bus.oEXOUT_VALID), PW'(0));
    chk("rst_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(0));
    chk("rst_ptr",   PW'(bus.oINFO_RR_POINTER), PW'(0));
    rst = 1'b0;
    #1;
    chk("rel_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b0001));

    // Round robin with entries refilling as they are granted.
    for (int j = 1; j <= 4; j++) begin
      step();
      pay[j-1] = mkpay(6'(20 + j - 1), 32'h200 + j);
      #1;
      one = '0; one[j % 4] = 1'b1;
      chk("rr_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(one));
      chk("rr_tag",   PW'(bus.oEXOUT_PAYLOAD[37:32]), PW'(10 + j - 1));
    end
    step(); ev = 4'b0010; #1;
    chk("rr_tag_wrap", PW'(bus.oEXOUT_PAYLOAD[37:32]), PW'(20));
    chk("rr_ptr_wrap", PW'(bus.oINFO_RR_POINTER), PW'(1));
    chk("rr_g1",       PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b0010));

    // Priority from pointer.
    step(); ev = 4'b0011; pay[0] = mkpay(6'd30, 32'h300); pay[1] = mkpay(6'd31, 32'h301); #1;
    chk("pri_ptr2",  PW'(bus.oINFO_RR_POINTER), PW'(2));
    chk("pri_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b0001));
    step(); ev = 4'b0110; pay[2] = mkpay(6'd32, 32'h302); #1;
    chk("pri_ptr1",   PW'(bus.oINFO_RR_POINTER), PW'(1));
    chk("pri_grant2", PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b0010));

    // Stall: load entry 3, then hold lock.
    step(); ev = 4'b1000; pay[3] = mkpay(6'd33, 32'h0000_1000); #1;
    chk("st_load", PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b1000));
    step(); ev = 4'b0001; lk = 1'b1; pay[0] = mkpay(6'd34, 32'h2000); #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) step();
      #1;
      lit_slot("st_hold", 1'b1, 6'd33, 32'h0000_1000);
      chk("st_nogrant", PW'(bus.oENTRY_EXOUT_VALID), PW'(0));
      chk("st_ptr",     PW'(bus.oINFO_RR_POINTER), PW'(0));
    end
    step(); lk = 1'b0; #1;
    chk("st_release", PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b0001));
    step(); ev = 4'b0000; #1;
    lit_slot("st_next", 1'b1, 6'd34, 32'h2000);

    // Flush while the slot is valid and locked.
    step(); ev = 4'b0010; pay[1] = mkpay(6'd35, 32'h3000); #1;
    chk("fl_pre_valid", PW'(bus.oEXOUT_VALID), PW'(0));
    chk("fl_pre_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b0010));
    step(); ev = 4'b0100; lk = 1'b1; fl = 1'b1; pay[2] = mkpay(6'd36, 32'h4000); #1;
    chk("fl_valid", PW'(bus.oEXOUT_VALID), PW'(1));
    chk("fl_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(0));
    step(); fl = 1'b0; #1;
    chk("fl_post_valid", PW'(bus.oEXOUT_VALID), PW'(0));
    chk("fl_post_ptr",   PW'(bus.oINFO_RR_POINTER), PW'(2));
    chk("fl_post_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(4'b0100));
    step(); ev = 4'b0000; lk = 1'b0; mt = 4'b1000; #1;
    lit_slot("fl_load", 1'b1, 6'd36, 32'h4000);
    chk("fl_load_ptr", PW'(bus.oINFO_RR_POINTER), PW'(3));

    // Matching but unoccupied entry is ignored.
    repeat (2) begin
      step(); #1;
      chk("mask_grant", PW'(bus.oENTRY_EXOUT_VALID), PW'(0));
    end
    chk("mask_valid", PW'(bus.oEXOUT_VALID), PW'(0));

    // Randomised traffic; entries free themselves one cycle after a grant.
    for (int n = 0; n < 400; n++) begin
      step();
      for (int k = 0; k < ENTRY; k++) if (m_gnt[k]) ev[k] = 1'b0;
      for (int k = 0; k < ENTRY; k++)
        if (!ev[k] && $urandom_range(1, 0) == 1) begin
          ev[k]  = 1'b1;
          pay[k] = mkpay(6'($urandom), $urandom);
        end
      mt  = 4'($urandom | $urandom);
      lk  = ($urandom_range(9, 0) < 3);
      fl  = ($urandom_range(19, 0) == 0);
      rst = ($urandom_range(49, 0) == 0);
    end
    step();
    rst = 1'b0; fl = 1'b0; lk = 1'b0;
    repeat (2) @(posedge clk);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
